// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the direct-mapped write-through data cache responder.
package dcache_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU,
        RESP
    } state_e;

    localparam int unsigned  LINES_DEFAULT   = 16;
    localparam logic [31:0]  IO_BASE_DEFAULT = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Core-side and backing-memory-side signals of the data cache responder.
interface dcache_responder_if;

    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_we;
    logic        core_re;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  core_addr, core_wdata, core_we, core_re, mem_ack, mem_rdata,
        output core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_addr, core_wdata, core_we, core_re, mem_ack, mem_rdata,
        input  core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_responder_array.sv
// Tag/valid/data storage: one write port, one combinational read port on a shared index.
module dcache_array #(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDXW  = $clog2(LINES),
    parameter int unsigned TAGW  = 30 - IDXW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] idx_i,
    input  logic            we_i,
    input  logic [TAGW-1:0] wtag_i,
    input  logic [31:0]     wdata_i,
    output logic            rvalid_o,
    output logic [TAGW-1:0] rtag_o,
    output logic [31:0]     rdata_o
);

    logic [LINES-1:0] valid_q;
    logic [TAGW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Only valid bits are reset; tags and data are don't-care until validated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[idx_i]  <= wtag_i;
            data_q[idx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[idx_i];
    assign rtag_o   = tag_q[idx_i];
    assign rdata_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache between a stalling core and backing memory.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int unsigned LINES   = LINES_DEFAULT,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    dcache_responder_if.slave  bus
);

    localparam int unsigned IDXW = $clog2(LINES);
    localparam int unsigned TAGW = 30 - IDXW;

    state_e          state_q, state_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     addr_al;
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic            is_io;
    logic            hit;
    logic            arr_we;
    logic [31:0]     arr_wdata;
    logic            arr_valid;
    logic [TAGW-1:0] arr_tag;
    logic [31:0]     arr_data;
    logic            unused_addr_lsb;

    assign addr_al         = word_align(bus.core_addr);
    assign idx             = bus.core_addr[IDXW+1:2];
    assign tag             = bus.core_addr[31:IDXW+2];
    assign is_io           = (addr_al >= IO_BASE);
    assign hit             = arr_valid && (arr_tag == tag);
    assign unused_addr_lsb = &{1'b0, bus.core_addr[1:0]};

    dcache_array #(
        .LINES (LINES),
        .IDXW  (IDXW),
        .TAGW  (TAGW)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .idx_i    (idx),
        .we_i     (arr_we),
        .wtag_i   (tag),
        .wdata_i  (arr_wdata),
        .rvalid_o (arr_valid),
        .rtag_o   (arr_tag),
        .rdata_o  (arr_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rdata_d        = rdata_q;
        arr_we         = 1'b0;
        arr_wdata      = '0;
        bus.core_rdata = '0;
        bus.core_stall = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                // Stores win over loads when both are requested.
                if (!is_io && bus.core_we) begin
                    bus.core_stall = 1'b1;
                    state_d        = WR_THRU;
                end else if (!is_io && bus.core_re) begin
                    if (hit) begin
                        bus.core_rdata = arr_data;
                    end else begin
                        bus.core_stall = 1'b1;
                        state_d        = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                bus.core_stall = 1'b1;
                bus.mem_req    = 1'b1;
                bus.mem_addr   = addr_al;
                if (bus.mem_ack) begin
                    arr_we    = 1'b1;
                    arr_wdata = bus.mem_rdata;
                    rdata_d   = bus.mem_rdata;
                    state_d   = RESP;
                end
            end
            WR_THRU: begin
                bus.core_stall = 1'b1;
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = addr_al;
                bus.mem_wdata  = bus.core_wdata;
                if (bus.mem_ack) begin
                    arr_we    = hit;
                    arr_wdata = bus.core_wdata;
                    state_d   = RESP;
                end
            end
            RESP: begin
                bus.core_rdata = rdata_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed scoreboard bench for dcache_responder with a behavioural backing memory.
module tb_dcache_responder;
    import dcache_responder_pkg::*;

    logic clk;
    logic reset;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned stalls;

    logic [31:0] exp_q[$];
    logic [31:0] mem_model [logic [31:0]];

    dcache_responder_if bus();

    dcache_responder #(
        .LINES   (LINES_DEFAULT),
        .IO_BASE (IO_BASE_DEFAULT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, bus.core_rdata);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.core_rdata, e);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.core_we   = 1'b0;
        bus.core_re   = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic do_load(input logic [31:0] addr, input bit hit, input int unsigned wait_cyc);
        @(negedge clk);
        bus.core_addr = addr;
        bus.core_re   = 1'b1;
        bus.core_we   = 1'b0;
        bus.mem_ack   = 1'b0;
        exp_q.push_back(mem_model[addr]);
        #1;
        if (hit) begin
            chk("ld_hit_stall", {31'b0, bus.core_stall}, 32'd0);
            chk("ld_hit_memreq", {31'b0, bus.mem_req}, 32'd0);
            pop_chk("ld_hit_data");
        end else begin
            chk("ld_miss_stall0", {31'b0, bus.core_stall}, 32'd1);
            chk("ld_miss_memreq0", {31'b0, bus.mem_req}, 32'd0);
            for (int i = 0; i <= int'(wait_cyc); i++) begin
                @(negedge clk);
                bus.mem_ack   = (i == int'(wait_cyc));
                bus.mem_rdata = (i == int'(wait_cyc)) ? mem_model[addr] : 32'h0BAD_0000;
                #1;
                chk("rd_memreq", {31'b0, bus.mem_req}, 32'd1);
                chk("rd_memwe", {31'b0, bus.mem_we}, 32'd0);
                chk("rd_memaddr", bus.mem_addr, addr);
                chk("rd_stall", {31'b0, bus.core_stall}, 32'd1);
            end
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
            #1;
            chk("resp_stall", {31'b0, bus.core_stall}, 32'd0);
            chk("resp_memreq", {31'b0, bus.mem_req}, 32'd0);
            pop_chk("resp_data");
        end
        go_idle();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit also_re,
                            input int unsigned wait_cyc, output int unsigned n_stall);
        n_stall = 0;
        @(negedge clk);
        bus.core_addr  = addr;
        bus.core_wdata = data;
        bus.core_we    = 1'b1;
        bus.core_re    = also_re;
        bus.mem_ack    = 1'b0;
        #1;
        chk("st_stall0", {31'b0, bus.core_stall}, 32'd1);
        chk("st_memreq0", {31'b0, bus.mem_req}, 32'd0);
        if (bus.core_stall) n_stall++;
        for (int i = 0; i <= int'(wait_cyc); i++) begin
            @(negedge clk);
            bus.mem_ack = (i == int'(wait_cyc));
            #1;
            chk("wr_memreq", {31'b0, bus.mem_req}, 32'd1);
            chk("wr_memwe", {31'b0, bus.mem_we}, 32'd1);
            chk("wr_memaddr", bus.mem_addr, addr);
            chk("wr_memwdata", bus.mem_wdata, data);
            if (bus.core_stall) n_stall++;
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        chk("st_resp_stall", {31'b0, bus.core_stall}, 32'd0);
        chk("st_resp_memreq", {31'b0, bus.mem_req}, 32'd0);
        mem_model[addr] = data;
        go_idle();
    endtask

    initial begin
        mem_model[32'h0000_0100] = 32'hDEAD_BEEF;
        mem_model[32'h0000_0140] = 32'hCAFE_F00D;
        mem_model[32'h0000_0180] = 32'h1111_2222;
        mem_model[32'h0000_0200] = 32'h55AA_55AA;

        reset          = 1'b1;
        bus.core_addr  = 32'h0;
        bus.core_wdata = 32'h0;
        bus.core_we    = 1'b0;
        bus.core_re    = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, bus.core_stall}, 32'd0);
        chk("rst_memreq", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_memwe", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_rdata", bus.core_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_memaddr", bus.mem_addr, 32'd0);
        chk("idle_memwdata", bus.mem_wdata, 32'd0);

        // Cold miss, then hit.
        do_load(32'h0000_0100, 1'b0, 2);
        do_load(32'h0000_0100, 1'b1, 0);

        // Write-through hit: ack on the fifth memory cycle -> six stall cycles.
        do_store(32'h0000_0100, 32'h1234_5678, 1'b0, 4, stalls);
        chk("st_stall_count", stalls, 32'd6);
        do_load(32'h0000_0100, 1'b1, 0);

        // Conflict on index 0: 0x140 evicts 0x100.
        do_load(32'h0000_0140, 1'b0, 0);
        do_load(32'h0000_0100, 1'b0, 3);

        // Write miss to 0x180 (same index) leaves the 0x100 line intact.
        do_store(32'h0000_0180, 32'hA5A5_0001, 1'b0, 0, stalls);
        chk("st_miss_stall_count", stalls, 32'd2);
        do_load(32'h0000_0100, 1'b1, 0);
        do_load(32'h0000_0180, 1'b0, 1);

        // Load and store together behave as a store (hit updates line).
        do_store(32'h0000_0180, 32'h0BAD_C0DE, 1'b1, 1, stalls);
        do_load(32'h0000_0180, 1'b1, 0);

        // IO word: no memory traffic, no stall, reads return zero.
        @(negedge clk);
        bus.core_addr  = 32'hFFFF_FFFC;
        bus.core_wdata = 32'h9999_9999;
        bus.core_we    = 1'b1;
        #1;
        chk("io_wr_stall", {31'b0, bus.core_stall}, 32'd0);
        chk("io_wr_memreq", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        bus.core_we = 1'b0;
        bus.core_re = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        chk("io_rd_stall", {31'b0, bus.core_stall}, 32'd0);
        chk("io_rd_memreq", {31'b0, bus.mem_req}, 32'd0);
        pop_chk("io_rd_data");
        go_idle();

        // Spurious ack while idle must be ignored.
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("spur_memreq", {31'b0, bus.mem_req}, 32'd0);
        chk("spur_stall", {31'b0, bus.core_stall}, 32'd0);
        go_idle();
        do_load(32'h0000_0180, 1'b1, 0);

        // Reset during RD_MISS abandons the refill and invalidates the cache.
        @(negedge clk);
        bus.core_addr = 32'h0000_0200;
        bus.core_re   = 1'b1;
        #1;
        chk("abort_stall0", {31'b0, bus.core_stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("abort_memreq1", {31'b0, bus.mem_req}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_memreq_rst", {31'b0, bus.mem_req}, 32'd0);
        chk("abort_memwe_rst", {31'b0, bus.mem_we}, 32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.core_re   = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        #1;
        chk("post_rst_memreq", {31'b0, bus.mem_req}, 32'd0);
        go_idle();
        #1;
        chk("post_rst_stall", {31'b0, bus.core_stall}, 32'd0);
        chk("post_rst_rdata", bus.core_rdata, 32'd0);
        do_load(32'h0000_0180, 1'b0, 0);
        do_load(32'h0000_0100, 1'b0, 1);
        do_load(32'h0000_0100, 1'b1, 0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
